// File: rtl/prism_cfg_pkg.sv
// prism_cfg_pkg: shared definitions for the prism configuration loader.
//   cfg_state_e        - loader FSM state encoding (also exposed on dbg_state)
//   CFG_HEADER_DEFAULT - default frame header byte
//   CRC8_POLY          - CRC-8 polynomial (x^8 + x^2 + x + 1)
//   crc8_byte()        - folds one byte into a running CRC-8 (MSB first,
//                        no reflection, no final XOR)
package prism_cfg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HDR   = 3'd1,
        ST_LEN   = 3'd2,
        ST_DATA  = 3'd3,
        ST_CRC   = 3'd4,
        ST_DRAIN = 3'd5,
        ST_ERR   = 3'd6
    } cfg_state_e;

    localparam logic [7:0] CFG_HEADER_DEFAULT = 8'hA5;
    localparam logic [7:0] CRC8_POLY          = 8'h07;

    function automatic logic [7:0] crc8_byte(input logic [7:0] crc_in,
                                             input logic [7:0] data_in);
        logic [7:0] c;
        c = crc_in ^ data_in;
        for (int i = 0; i < 8; i++) begin
            if (c[7]) c = {c[6:0], 1'b0} ^ CRC8_POLY;
            else      c = {c[6:0], 1'b0};
        end
        return c;
    endfunction

endpackage

// File: rtl/prism_cfg_fifo.sv
// prism_cfg_fifo: small synchronous FIFO between the SPI byte receiver and
// the bit shifter. Read data is show-ahead (data_o is the head entry while
// empty_o is low). Flush empties the FIFO and wins over push/pop.
// Ports:
//   clk, rst        - clock, asynchronous active-high reset
//   push_i, data_i  - write strobe and data (ignored when full)
//   pop_i           - remove head entry (ignored when empty)
//   flush_i         - discard all entries
//   data_o          - head entry
//   full_o, empty_o - occupancy flags
module prism_cfg_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    input  logic             flush_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem_q [DEPTH];
    // Pointers carry one extra wrap bit to tell full from empty.
    logic [AW:0] wr_ptr_q;
    logic [AW:0] rd_ptr_q;
    logic        do_push;
    logic        do_pop;

    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign do_push = push_i && !full_o && !flush_i;
    assign do_pop  = pop_i && !empty_o && !flush_i;
    assign data_o  = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
    end

endmodule

// File: rtl/prism_cfg_loader.sv
// prism_cfg_loader: SPI (mode 0, MSB first) configuration front end.
// Receives HEADER, LEN, LEN payload bytes [, CRC-8] and streams the payload
// MSB first into the prism configuration chain, then pulses cfg_latch.
// Optional feature macro: PRISM_CFG_CRC_EN adds a trailing CRC-8 byte
// (poly 0x07, init 0) computed over LEN and payload.
// Ports:
//   clk, rst                     - clock, asynchronous active-high reset
//   spi_sclk, spi_cs_n, spi_mosi - asynchronous host SPI pins
//   cfg_data, cfg_shift          - chain data bit and shift enable
//   cfg_latch                    - one-cycle commit pulse
//   busy                         - frame in progress or shifter draining
//   err                          - sticky error, cleared on next cs_n fall
//   dbg_state                    - current FSM state
//
// Handshake: the receiver presents a byte with rx_valid_q for exactly one
// cycle; the FSM consumes it that cycle (no back-pressure). The FIFO pops
// whenever the shifter can take a byte; push is only issued when not full.
module prism_cfg_loader
    import prism_cfg_pkg::*;
#(
    parameter int         FIFO_DEPTH = 2,
    parameter logic [7:0] HEADER     = CFG_HEADER_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       spi_sclk,
    input  logic       spi_cs_n,
    input  logic       spi_mosi,
    output logic       cfg_data,
    output logic       cfg_shift,
    output logic       cfg_latch,
    output logic       busy,
    output logic       err,
    output cfg_state_e dbg_state
);

    // ---------------- synchronizers and edge detect ----------------
    logic [1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
    logic       sclk_prev_q, cs_prev_q;
    logic       sclk_s, cs_s, mosi_s;
    logic       sclk_rise, cs_fall, cs_rise;

    assign sclk_s    = sclk_sync_q[1];
    assign cs_s      = cs_sync_q[1];
    assign mosi_s    = mosi_sync_q[1];
    assign sclk_rise = sclk_s && !sclk_prev_q;
    assign cs_fall   = cs_prev_q && !cs_s;
    assign cs_rise   = !cs_prev_q && cs_s;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_sync_q <= 2'b00;
            cs_sync_q   <= 2'b11;
            mosi_sync_q <= 2'b00;
            sclk_prev_q <= 1'b0;
            cs_prev_q   <= 1'b1;
        end else begin
            sclk_sync_q <= {sclk_sync_q[0], spi_sclk};
            cs_sync_q   <= {cs_sync_q[0], spi_cs_n};
            mosi_sync_q <= {mosi_sync_q[0], spi_mosi};
            sclk_prev_q <= sclk_s;
            cs_prev_q   <= cs_s;
        end
    end

    // ---------------- byte receiver ----------------
    logic [2:0] rx_cnt_q;
    logic [6:0] rx_sr_q;
    logic [7:0] rx_byte_q;
    logic       rx_valid_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_cnt_q   <= '0;
            rx_sr_q    <= '0;
            rx_byte_q  <= '0;
            rx_valid_q <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            if (cs_s) begin
                rx_cnt_q <= '0;
            end else if (sclk_rise) begin
                rx_sr_q  <= {rx_sr_q[5:0], mosi_s};
                rx_cnt_q <= rx_cnt_q + 3'd1;
                if (rx_cnt_q == 3'd7) begin
                    rx_byte_q  <= {rx_sr_q, mosi_s};
                    rx_valid_q <= 1'b1;
                end
            end
        end
    end

    // ---------------- FIFO ----------------
    logic       fifo_push, fifo_pop, fifo_flush;
    logic       fifo_full, fifo_empty;
    logic [7:0] fifo_dout;

    prism_cfg_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .push_i (fifo_push),
        .data_i (rx_byte_q),
        .pop_i  (fifo_pop),
        .flush_i(fifo_flush),
        .data_o (fifo_dout),
        .full_o (fifo_full),
        .empty_o(fifo_empty)
    );

    // ---------------- frame FSM ----------------
    cfg_state_e state_q, state_d;
    logic [7:0] len_q, len_d;
    logic [7:0] cnt_q, cnt_d;
    logic       err_q, err_d;
    logic       latch;
    logic       abort;
    logic       shift_active_q;
`ifdef PRISM_CFG_CRC_EN
    logic [7:0] crc_q, crc_d;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            len_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
`ifdef PRISM_CFG_CRC_EN
            crc_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
`ifdef PRISM_CFG_CRC_EN
            crc_q   <= crc_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        cnt_d      = cnt_q;
        err_d      = err_q;
        fifo_push  = 1'b0;
        fifo_flush = 1'b0;
        latch      = 1'b0;
`ifdef PRISM_CFG_CRC_EN
        crc_d      = crc_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (cs_fall) begin
                    err_d   = 1'b0;
                    cnt_d   = '0;
                    len_d   = '0;
`ifdef PRISM_CFG_CRC_EN
                    crc_d   = '0;
`endif
                    state_d = ST_HDR;
                end
            end
            ST_HDR: begin
                if (rx_valid_q) state_d = (rx_byte_q == HEADER) ? ST_LEN : ST_ERR;
            end
            ST_LEN: begin
                if (rx_valid_q) begin
                    if (rx_byte_q == 8'd0) begin
                        state_d = ST_ERR;
                    end else begin
                        len_d   = rx_byte_q;
`ifdef PRISM_CFG_CRC_EN
                        crc_d   = crc8_byte(crc_q, rx_byte_q);
`endif
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (rx_valid_q) begin
                    if (fifo_full) begin
                        state_d = ST_ERR;
                    end else begin
                        fifo_push = 1'b1;
                        cnt_d     = cnt_q + 8'd1;
`ifdef PRISM_CFG_CRC_EN
                        crc_d     = crc8_byte(crc_q, rx_byte_q);
                        if (cnt_d == len_q) state_d = ST_CRC;
`else
                        if (cnt_d == len_q) state_d = ST_DRAIN;
`endif
                    end
                end
            end
`ifdef PRISM_CFG_CRC_EN
            ST_CRC: begin
                if (rx_valid_q) state_d = (rx_byte_q == crc_q) ? ST_DRAIN : ST_ERR;
            end
`endif
            ST_DRAIN: begin
                if (fifo_empty && !shift_active_q) begin
                    latch   = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_ERR: begin
                if (cs_s) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Host releasing cs_n before the frame is complete is an error,
        // unless the same cycle's byte just completed the frame.
        if (cs_rise && (state_q inside {ST_HDR, ST_LEN, ST_DATA, ST_CRC}) &&
            (state_d != ST_DRAIN)) begin
            state_d = ST_ERR;
        end

        if (state_d == ST_ERR) begin
            err_d      = 1'b1;
            fifo_flush = 1'b1;
        end
    end

    // Abort on the same edge that enters ERR so no further bits escape.
    assign abort = (state_d == ST_ERR);

    // ---------------- bit shifter ----------------
    logic [7:0] shift_sr_q;
    logic [2:0] shift_cnt_q;

    // Popping during the 8th bit lets consecutive bytes shift without a gap.
    assign fifo_pop = !fifo_empty && !abort &&
                      (!shift_active_q || (shift_cnt_q == 3'd7));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_active_q <= 1'b0;
            shift_sr_q     <= '0;
            shift_cnt_q    <= '0;
        end else if (abort) begin
            shift_active_q <= 1'b0;
            shift_sr_q     <= '0;
            shift_cnt_q    <= '0;
        end else if (fifo_pop) begin
            shift_active_q <= 1'b1;
            shift_sr_q     <= fifo_dout;
            shift_cnt_q    <= '0;
        end else if (shift_active_q) begin
            shift_sr_q  <= {shift_sr_q[6:0], 1'b0};
            shift_cnt_q <= shift_cnt_q + 3'd1;
            if (shift_cnt_q == 3'd7) shift_active_q <= 1'b0;
        end
    end

    // ---------------- outputs ----------------
    assign cfg_shift = shift_active_q;
    assign cfg_data  = shift_active_q & shift_sr_q[7];
    assign cfg_latch = latch;
    assign busy      = (state_q != ST_IDLE) && (state_q != ST_ERR);
    assign err       = err_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_prism_cfg_loader.sv
`timescale 1ns/1ps
module tb_prism_cfg_loader;
  import prism_cfg_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic spi_sclk = 1'b0;
  logic spi_cs_n = 1'b1;
  logic spi_mosi = 1'b0;
  logic cfg_data, cfg_shift, cfg_latch, busy, err;
  cfg_state_e dbg_state;

  always #5 clk = ~clk;

  prism_cfg_loader #(.FIFO_DEPTH(2), .HEADER(8'hA5)) dut (
    .clk(clk), .rst(rst),
    .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi),
    .cfg_data(cfg_data), .cfg_shift(cfg_shift), .cfg_latch(cfg_latch),
    .busy(busy), .err(err), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [0:0] exp_q[$];
  int latch_seen = 0;
  int latch_exp = 0;
  bit mon_ignore = 1'b0;
  logic prev_shift = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // ---------------- reference model ----------------
  // CRC-8 as polynomial long division of message * x^8 by 0x107.
  function automatic logic [7:0] model_crc(input logic [7:0] msg[$]);
    logic [8:0] r;
    r = 9'd0;
    foreach (msg[k]) begin
      for (int i = 7; i >= 0; i--) begin
        r = {r[7:0], msg[k][i]};
        if (r[8]) r = r ^ 9'h107;
      end
    end
    for (int i = 0; i < 8; i++) begin
      r = {r[7:0], 1'b0};
      if (r[8]) r = r ^ 9'h107;
    end
    return r[7:0];
  endfunction

  task automatic expect_bytes(input logic [7:0] bytes[$]);
    foreach (bytes[k])
      for (int i = 7; i >= 0; i--) exp_q.push_back(bytes[k][i]);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!rst && !mon_ignore) begin
      if (cfg_shift) begin
        if (exp_q.size() == 0) check("unexpected_shift", 32'd1, 32'd0);
        else check("cfg_data", {31'd0, cfg_data}, {31'd0, exp_q.pop_front()});
      end
      if (cfg_latch) begin
        latch_seen++;
        check("latch_bits_left", exp_q.size(), 32'd0);
`ifndef PRISM_CFG_CRC_EN
        check("latch_after_last_shift", {31'd0, prev_shift}, 32'd1);
`endif
      end
    end
    prev_shift = cfg_shift;
  end

  // ---------------- driver tasks ----------------
  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // sclk = clk/8, mosi changes on the falling edge (mode 0).
  task automatic spi_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      spi_mosi = b[i];
      wait_clks(4);
      spi_sclk = 1'b1;
      wait_clks(4);
      spi_sclk = 1'b0;
    end
  endtask

  task automatic cs_begin();
    spi_cs_n = 1'b0;
    wait_clks(8);
  endtask

  task automatic cs_end();
    wait_clks(16);
    spi_cs_n = 1'b1;
    wait_clks(8);
  endtask

  task automatic end_checks(input string name, input logic exp_err);
    int n;
    n = 0;
    while (busy && n < 600) begin
      @(negedge clk);
      n++;
    end
    check({name, "_idle_timeout"}, {31'd0, busy}, 32'd0);
    wait_clks(6);
    check({name, "_err"}, {31'd0, err}, {31'd0, exp_err});
    check({name, "_latch_count"}, latch_seen, latch_exp);
    check({name, "_bits_left"}, exp_q.size(), 32'd0);
    check({name, "_fifo_empty"}, {31'd0, dut.fifo_empty}, 32'd1);
  endtask

  // corrupt: send a wrong CRC byte (CRC builds only); n_extra: bytes after frame.
  task automatic send_frame(input string name, input logic [7:0] pl[$], input bit corrupt, input int n_extra);
    logic [7:0] len;
    logic [7:0] m[$];
    logic [7:0] crc;
    len = 8'(pl.size());
    m = pl;
    m.push_front(len);
    crc = model_crc(m);
    expect_bytes(pl);
`ifdef PRISM_CFG_CRC_EN
    if (!corrupt) latch_exp++;
`else
    latch_exp++;
`endif
    cs_begin();
    check({name, "_err_clear_on_cs_fall"}, {31'd0, err}, 32'd0);
    spi_byte(8'hA5);
    check({name, "_busy"}, {31'd0, busy}, 32'd1);
    spi_byte(len);
    foreach (pl[k]) spi_byte(pl[k]);
`ifdef PRISM_CFG_CRC_EN
    spi_byte(corrupt ? (crc ^ 8'h5A) : crc);
`endif
    for (int k = 0; k < n_extra; k++) spi_byte(8'($urandom_range(0, 255)));
    cs_end();
`ifdef PRISM_CFG_CRC_EN
    end_checks(name, corrupt);
`else
    end_checks(name, 1'b0);
`endif
  endtask

  task automatic random_payload(output logic [7:0] pl[$], input int len);
    pl.delete();
    for (int k = 0; k < len; k++) pl.push_back(8'($urandom_range(0, 255)));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] pl[$];
    int n;
    int latch_before;

    wait_clks(3);
    rst = 1'b0;
    wait_clks(1);
    check("rst_cfg_data", {31'd0, cfg_data}, 32'd0);
    check("rst_cfg_shift", {31'd0, cfg_shift}, 32'd0);
    check("rst_cfg_latch", {31'd0, cfg_latch}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    wait_clks(4);

    // Basic frame A5 02 3C C3.
    pl = '{8'h3C, 8'hC3};
    send_frame("basic", pl, 1'b0, 0);

    // Wrong header.
    cs_begin();
    spi_byte(8'h5A);
    wait_clks(6);
    check("bad_hdr_err", {31'd0, err}, 32'd1);
    spi_byte(8'h02);
    spi_byte(8'h11);
    cs_end();
    end_checks("bad_hdr", 1'b1);

    // LEN = 0, then a normal frame recovers.
    cs_begin();
    spi_byte(8'hA5);
    spi_byte(8'h00);
    wait_clks(6);
    check("len0_err", {31'd0, err}, 32'd1);
    cs_end();
    end_checks("len0", 1'b1);
    random_payload(pl, 3);
    send_frame("after_len0", pl, 1'b0, 0);

    // cs_n raised after 1 of 3 payload bytes.
    random_payload(pl, 1);
    expect_bytes(pl);
    cs_begin();
    spi_byte(8'hA5);
    spi_byte(8'h03);
    spi_byte(pl[0]);
    cs_end();
    end_checks("cs_abort", 1'b1);

    // Bytes after the frame with cs_n still low are ignored.
    random_payload(pl, 2);
    send_frame("trailing", pl, 1'b0, 2);

`ifdef PRISM_CFG_CRC_EN
    random_payload(pl, 3);
    send_frame("bad_crc", pl, 1'b1, 0);
`endif

    // Randomized frames.
    for (int f = 0; f < 6; f++) begin
      random_payload(pl, $urandom_range(1, 5));
      send_frame("rand", pl, 1'b0, 0);
    end

    // Reset during the 5th shift cycle.
    mon_ignore = 1'b1;
    latch_before = latch_seen;
    random_payload(pl, 1);
    cs_begin();
    spi_byte(8'hA5);
    spi_byte(8'h03);
    spi_byte(pl[0]);
    n = 0;
    while (!cfg_shift && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("rst_test_shift_start", {31'd0, cfg_shift}, 32'd1);
    wait_clks(4);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_cfg_shift", {31'd0, cfg_shift}, 32'd0);
    check("midrst_cfg_data", {31'd0, cfg_data}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_state", 32'(dbg_state), 32'(ST_IDLE));
    spi_cs_n = 1'b1;
    wait_clks(6);
    rst = 1'b0;
    wait_clks(40);
    check("midrst_no_latch", latch_seen, latch_before);
    check("midrst_err", {31'd0, err}, 32'd0);
    check("midrst_fifo_empty", {31'd0, dut.fifo_empty}, 32'd1);
    exp_q.delete();
    mon_ignore = 1'b0;

    random_payload(pl, 2);
    send_frame("after_rst", pl, 1'b0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard time limit in case a driver task is stuck.
  initial begin
    #3000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
